// File: rtl/rams_bank_dispatch.sv
// rams_bank_dispatch
// Dispatches valid/ready requests from NUM_PORTS requesters onto NUM_RAMS
// single-port, read-first, registered-output RAM banks. Each bank has its own
// round-robin arbiter. The bank controls are registered. Every accepted access
// returns a one-cycle response pulse to its originating port exactly two
// cycles after the accept edge.
//
// Ports
//   clk, rst        : clock; asynchronous active-high reset
//   req_valid/ready : per-port handshake (ready is combinational)
//   req_we/bank/addr/din : per-port access fields
//   ram_ena/we/addr/din  : registered per-bank RAM controls
//   ram_dout        : per-bank RAM read data (valid one cycle after ena)
//   rsp_valid/data  : per-port response pulse and held data
//   conflict_cnt    : saturating count of cycles with a denied request
module rams_bank_dispatch #(
    parameter int NUM_RAMS  = 2,
    parameter int NUM_PORTS = 2,
    parameter int A_WID     = 10,
    parameter int D_WID     = 32,
    parameter int B_WID     = $clog2(NUM_RAMS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                req_valid,
    output logic [NUM_PORTS-1:0]                req_ready,
    input  logic [NUM_PORTS-1:0]                req_we,
    input  logic [NUM_PORTS-1:0][B_WID-1:0]     req_bank,
    input  logic [NUM_PORTS-1:0][A_WID-1:0]     req_addr,
    input  logic [NUM_PORTS-1:0][D_WID-1:0]     req_din,
    output logic [NUM_RAMS-1:0]                 ram_ena,
    output logic [NUM_RAMS-1:0]                 ram_we,
    output logic [NUM_RAMS-1:0][A_WID-1:0]      ram_addr,
    output logic [NUM_RAMS-1:0][D_WID-1:0]      ram_din,
    input  logic [NUM_RAMS-1:0][D_WID-1:0]      ram_dout,
    output logic [NUM_PORTS-1:0]                rsp_valid,
    output logic [NUM_PORTS-1:0][D_WID-1:0]     rsp_data,
    output logic [15:0]                         conflict_cnt
);

    localparam int P_WID = $clog2(NUM_PORTS);

    // Arbitration state and issue registers
    logic [NUM_RAMS-1:0][P_WID-1:0]  r_rr_ptr;
    logic [NUM_RAMS-1:0]             r_ena;
    logic [NUM_RAMS-1:0]             r_we;
    logic [NUM_RAMS-1:0][A_WID-1:0]  r_addr;
    logic [NUM_RAMS-1:0][D_WID-1:0]  r_din;

    // Tag pipeline: stage 1 rides with the issue register, stage 2 with ram_dout
    logic [NUM_RAMS-1:0]             r_t1_vld;
    logic [NUM_RAMS-1:0][P_WID-1:0]  r_t1_port;
    logic [NUM_RAMS-1:0]             r_t2_vld;
    logic [NUM_RAMS-1:0][P_WID-1:0]  r_t2_port;

    // Response and statistics registers
    logic [NUM_PORTS-1:0]            r_rsp_vld;
    logic [NUM_PORTS-1:0][D_WID-1:0] r_rsp_data;
    logic [15:0]                     r_cnt;

    logic [NUM_RAMS-1:0]             w_gnt_vld;
    logic [NUM_RAMS-1:0][P_WID-1:0]  w_gnt_port;
    logic [NUM_RAMS-1:0][P_WID-1:0]  w_nxt_ptr;
    logic [NUM_PORTS-1:0]            w_ready;
    logic [NUM_PORTS-1:0]            w_rsp_hit;
    logic [NUM_PORTS-1:0][D_WID-1:0] w_rsp_dat;
    logic                            w_conflict;

    // Per-bank round-robin: scan ports cyclically starting at rr_ptr.
    // A port names exactly one bank, so it can win in at most one bank.
    // Bank indices >= NUM_RAMS never match any b and therefore never win.
    always_comb begin
        int p;
        p          = 0;
        w_gnt_vld  = '0;
        w_gnt_port = '0;
        w_nxt_ptr  = r_rr_ptr;
        w_ready    = '0;
        for (int b = 0; b < NUM_RAMS; b++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                p = int'(r_rr_ptr[b]) + k;
                if (p >= NUM_PORTS) p = p - NUM_PORTS;
                if (!w_gnt_vld[b] && req_valid[p] && (int'(req_bank[p]) == b)) begin
                    w_gnt_vld[b]  = 1'b1;
                    w_gnt_port[b] = P_WID'(p);
                    w_ready[p]    = 1'b1;
                    w_nxt_ptr[b]  = (p == NUM_PORTS - 1) ? '0 : P_WID'(p + 1);
                end
            end
        end
        if (rst) w_ready = '0;
    end

    // Route each bank's read data back to the port that issued the access
    always_comb begin
        w_rsp_hit = '0;
        w_rsp_dat = r_rsp_data;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int b = 0; b < NUM_RAMS; b++) begin
                if (r_t2_vld[b] && (int'(r_t2_port[b]) == p)) begin
                    w_rsp_hit[p] = 1'b1;
                    w_rsp_dat[p] = ram_dout[b];
                end
            end
        end
    end

    assign w_conflict = |(req_valid & ~w_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_ena      <= '0;
            r_we       <= '0;
            r_addr     <= '0;
            r_din      <= '0;
            r_t1_vld   <= '0;
            r_t2_vld   <= '0;
            r_rsp_vld  <= '0;
            r_rsp_data <= '0;
            r_cnt      <= '0;
        end else begin
            r_rr_ptr <= w_nxt_ptr;
            // Issue stage: address/data hold when the bank is idle
            for (int b = 0; b < NUM_RAMS; b++) begin
                r_ena[b] <= w_gnt_vld[b];
                r_we[b]  <= w_gnt_vld[b] & req_we[w_gnt_port[b]];
                if (w_gnt_vld[b]) begin
                    r_addr[b] <= req_addr[w_gnt_port[b]];
                    r_din[b]  <= req_din[w_gnt_port[b]];
                end
            end
            // Tag stages advance every cycle, no stall
            r_t1_vld <= w_gnt_vld;
            r_t2_vld <= r_t1_vld;
            // Response stage
            r_rsp_vld  <= w_rsp_hit;
            r_rsp_data <= w_rsp_dat;
            if (w_conflict && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
        end
    end

    // Tag port indices are qualified by the valids, so they need no reset
    always_ff @(posedge clk) begin
        r_t1_port <= w_gnt_port;
        r_t2_port <= r_t1_port;
    end

    assign req_ready    = w_ready;
    assign ram_ena      = r_ena;
    assign ram_we       = r_we;
    assign ram_addr     = r_addr;
    assign ram_din      = r_din;
    assign rsp_valid    = r_rsp_vld;
    assign rsp_data     = r_rsp_data;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_rams_bank_dispatch.sv
module tb_rams_bank_dispatch;

    localparam int NR = 3;
    localparam int NP = 2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NP-1:0]         req_valid, req_ready, req_we;
    logic [NP-1:0][BW-1:0] req_bank;
    logic [NP-1:0][AW-1:0] req_addr;
    logic [NP-1:0][DW-1:0] req_din;
    logic [NR-1:0]         ram_ena, ram_we;
    logic [NR-1:0][AW-1:0] ram_addr;
    logic [NR-1:0][DW-1:0] ram_din, ram_dout;
    logic [NP-1:0]         rsp_valid;
    logic [NP-1:0][DW-1:0] rsp_data;
    logic [15:0]           conflict_cnt;

    logic          mem_clr;
    logic [DW-1:0] mem     [NR][1<<AW];
    logic [DW-1:0] ref_mem [NR][1<<AW];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    rams_bank_dispatch #(
        .NUM_RAMS(NR), .NUM_PORTS(NP), .A_WID(AW), .D_WID(DW), .B_WID(BW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_bank(req_bank), .req_addr(req_addr), .req_din(req_din),
        .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Read-first single-port RAM banks with registered output
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int b = 0; b < NR; b++)
                for (int a = 0; a < (1<<AW); a++)
                    mem[b][a] <= '0;
        end else begin
            for (int b = 0; b < NR; b++) begin
                if (ram_ena[b]) begin
                    ram_dout[b] <= mem[b][ram_addr[b]];
                    if (ram_we[b]) mem[b][ram_addr[b]] <= ram_din[b];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic we, input int bank,
                         input int addr, input logic [31:0] din);
        req_valid[p] = v;
        req_we[p]    = we;
        req_bank[p]  = BW'(bank);
        req_addr[p]  = AW'(addr);
        req_din[p]   = din;
    endtask

    // Record accepts into the scoreboard, advance one clock, check responses
    task automatic tick();
        logic [NP-1:0] acc;
        logic [NP-1:0] seen;
        exp_t e;
        int b;
        int a;
        #1;
        acc = req_valid & req_ready;
        for (int p = 0; p < NP; p++) begin
            if (acc[p]) begin
                b = int'(req_bank[p]);
                a = int'(req_addr[p]);
                e.port = p;
                e.data = ref_mem[b][a];
                e.due  = cyc + 3;
                q.push_back(e);
                if (req_we[p]) ref_mem[b][a] = req_din[p];
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        seen = '0;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("rsp_valid", 32'(rsp_valid[e.port]), 32'd1);
            chk("rsp_data", rsp_data[e.port], e.data);
            seen[e.port] = 1'b1;
        end
        for (int p = 0; p < NP; p++)
            if (!seen[p]) chk("rsp_spurious", 32'(rsp_valid[p]), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        mem_clr = 1'b1;
        req_valid = '0; req_we = '0; req_bank = '0; req_addr = '0; req_din = '0;
        for (int b = 0; b < NR; b++)
            for (int a = 0; a < (1<<AW); a++)
                ref_mem[b][a] = '0;

        // Reset state
        #1;
        chk("rst_ena", 32'(ram_ena), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        for (int b = 0; b < NR; b++) chk("rst_din", ram_din[b], 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int p = 0; p < NP; p++) chk("rst_rsp_data", rsp_data[p], 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        drive(0, 1'b1, 1'b0, 0, 0, 32'd0);
        drive(1, 1'b1, 1'b0, 0, 1, 32'd0);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        req_valid = '0;
        rst = 1'b0;
        mem_clr = 1'b0;
        tick();

        // Write, write, read on one location; read-first returns old content
        drive(0, 1'b1, 1'b1, 1, 5, 32'h11111111);
        #1;
        chk("wr1_ready", 32'(req_ready), 32'd1);
        tick();
        chk("wr1_ena", 32'(ram_ena), 32'b010);
        chk("wr1_we", 32'(ram_we), 32'b010);
        chk("wr1_addr", 32'(ram_addr[1]), 32'd5);
        chk("wr1_din", ram_din[1], 32'h11111111);
        drive(0, 1'b1, 1'b1, 1, 5, 32'hDEADBEEF);
        #1;
        chk("wr2_ready", 32'(req_ready), 32'd1);
        tick();
        drive(0, 1'b1, 1'b0, 1, 5, 32'd0);
        #1;
        chk("rd_ready", 32'(req_ready), 32'd1);
        tick();
        chk("rd_ena", 32'(ram_ena), 32'b010);
        chk("rd_we", 32'(ram_we), 32'd0);
        req_valid = '0;
        tick();
        tick();
        chk("rd_lat_valid", 32'(rsp_valid), 32'b01);
        chk("rd_lat_data", rsp_data[0], 32'hDEADBEEF);
        tick();
        chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
        chk("rsp_data_hold", rsp_data[0], 32'hDEADBEEF);

        // Parallel banks
        drive(0, 1'b1, 1'b0, 0, 3, 32'd0);
        drive(1, 1'b1, 1'b1, 1, 7, 32'hCAFE0001);
        #1;
        chk("par_ready", 32'(req_ready), 32'b11);
        tick();
        chk("par_ena", 32'(ram_ena), 32'b011);
        req_valid = '0;
        tick();
        tick();
        chk("par_rsp", 32'(rsp_valid), 32'b11);
        chk("par_cnt", 32'(conflict_cnt), 32'd0);

        // Port 1 alone on bank 0 so that bank 0 next favours port 0
        drive(1, 1'b1, 1'b0, 0, 3, 32'd0);
        #1;
        chk("ptr_ready", 32'(req_ready), 32'b10);
        tick();
        req_valid = '0;
        tick();
        tick();

        // Round-robin on bank 0
        drive(0, 1'b1, 1'b0, 0, 10, 32'd0);
        drive(1, 1'b1, 1'b0, 0, 11, 32'd0);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_grant", 32'(req_ready), (i % 2 == 0) ? 32'b01 : 32'b10);
            tick();
        end
        req_valid = '0;
        chk("rr_cnt", 32'(conflict_cnt), 32'd6);
        tick();
        tick();
        tick();

        // Out-of-range bank is never granted
        drive(1, 1'b1, 1'b0, 3, 0, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk("inv_ready", 32'(req_ready), 32'd0);
            tick();
            chk("inv_ena", 32'(ram_ena), 32'd0);
            chk("inv_cnt", 32'(conflict_cnt), 32'(6 + i));
        end
        req_valid = '0;
        tick();

        // Reset with two reads in flight
        drive(0, 1'b1, 1'b0, 0, 1, 32'd0);
        drive(1, 1'b1, 1'b0, 2, 2, 32'd0);
        #1;
        chk("mid_ready", 32'(req_ready), 32'b11);
        tick();
        req_valid = '0;
        rst = 1'b1;
        q.delete();
        #1;
        chk("mid_rst_ena", 32'(ram_ena), 32'd0);
        chk("mid_rst_cnt", 32'(conflict_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("mid_ena", 32'(ram_ena), 32'd0);
        chk("mid_we", 32'(ram_we), 32'd0);
        chk("mid_addr", 32'(ram_addr), 32'd0);
        for (int b = 0; b < NR; b++) chk("mid_din", ram_din[b], 32'd0);
        chk("mid_cnt", 32'(conflict_cnt), 32'd0);

        // Counter saturation
        drive(1, 1'b1, 1'b0, 3, 0, 32'd0);
        for (int i = 0; i < 65534; i++) tick();
        chk("sat_fffe", 32'(conflict_cnt), 32'hFFFE);
        tick();
        chk("sat_ffff", 32'(conflict_cnt), 32'hFFFF);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_hold", 32'(conflict_cnt), 32'hFFFF);
        req_valid = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rams_bank_dispatch.md
# rams_bank_dispatch

Multi-port request dispatcher that sits directly upstream of the per-bank single-port RAM array (NUM_RAMS independent banks, registered read-first output, `ena`/`we`/`addr`/`din` per bank). It accepts accesses from NUM_PORTS valid/ready requesters and arbitrates per bank with round-robin. It drives the bank control arrays from registers and routes each bank's `dout` back to the originating port as a tagged response pulse. A saturating conflict counter reports lost arbitration cycles.

## Interface
- NUM_RAMS, 2: number of banks; must be at least 2.
- NUM_PORTS, 2: number of requesters; must be at least 2.
- A_WID, 10: bank address width.
- D_WID, 32: data width.
- B_WID, $clog2(NUM_RAMS): bank-select width.
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  [NUM_PORTS-1:0]  request present, per port.
- req_ready  out  [NUM_PORTS-1:0]  grant, combinational from `req_valid` and RR state.
- req_we  in  [NUM_PORTS-1:0]  1 = write, 0 = read.
- req_bank  in  [B_WID-1:0] x NUM_PORTS  target bank.
- req_addr  in  [A_WID-1:0] x NUM_PORTS  word address.
- req_din  in  [D_WID-1:0] x NUM_PORTS  write data.
- ram_ena  out  [NUM_RAMS-1:0]  bank enable, registered.
- ram_we  out  [NUM_RAMS-1:0]  bank write enable, registered.
- ram_addr  out  [A_WID-1:0] x NUM_RAMS  registered.
- ram_din  out  [D_WID-1:0] x NUM_RAMS  registered.
- ram_dout  in  [D_WID-1:0] x NUM_RAMS  bank read data.
- rsp_valid  out  [NUM_PORTS-1:0]  one-cycle response pulse.
- rsp_data  out  [D_WID-1:0] x NUM_PORTS  response data.
- conflict_cnt  out  16  saturating count of denied-request cycles.

## Operation
- Transfer: a transfer occurs on a port when `req_valid & req_ready` is high at a rising edge.
- Per-bank arbitration: for each bank b, the candidates are the ports with `req_valid` high and `req_bank == b`.
  - Grant the first candidate at or after `rr_ptr[b]`, searching cyclically upward through the port indices.
  - On a grant, `rr_ptr[b]` becomes winner+1 (mod NUM_PORTS).
  - With no candidate, `rr_ptr[b]` holds.
- A port targets one bank per cycle, so it receives at most one grant per cycle. Different banks are served in parallel.
- `req_bank` values at or above NUM_RAMS are never granted; `req_ready` stays 0 for that port. The stall is permanent and the requester's responsibility.
- Issue register, at each edge, per bank:
  - Bank granted: `ram_ena[b]=1`, and `ram_we`/`ram_addr`/`ram_din` take the winner's fields.
  - Bank not granted: `ram_ena[b]=0` and `ram_we[b]=0`; `ram_addr` and `ram_din` hold.
- Tag pipeline: per bank, two stages of {valid, port index}, advancing every cycle with no stall.
  - Stage 1 is loaded together with the issue register.
  - Stage 2 aligns with `ram_dout` being valid.
- Response: at the edge after stage 2 is valid, `rsp_valid[p]` pulses for 1 cycle and `rsp_data[p]` is loaded from `ram_dout[b]`.
  - Every access responds, writes included. The RAM is read-first, so a write returns the old content.
  - At most one bank matches a given port per cycle.
  - `rsp_data` holds between pulses.
- conflict_cnt: +1 per cycle in which at least one port has `req_valid & ~req_ready`. It saturates at 0xFFFF.
- Reset (asynchronous assert):
  - Outputs: all `ram_*` outputs go to 0, `rsp_valid` to 0, `rsp_data` to 0, `conflict_cnt` to 0.
  - Internal state: all `rr_ptr` go to 0 and all tag-stage valids are cleared.
  - Effect: in-flight responses are dropped with no pulse.
  - `req_ready` is forced to 0 while `rst` is high.

## Timing
- Accept at edge E0 → `ram_ena` high after E0 → RAM captures at E1 → `ram_dout` valid after E1 → `rsp_valid` high after E2.
- Latency is fixed: the response appears 2 cycles after the accept edge. Throughput is 1 access per bank per cycle.
- Same-address accesses on one bank in consecutive cycles: the second response reflects the first write, because the RAM has already committed it.
- Responses to one port return in accept order: fixed latency guarantees this.
- The requester must hold `req_valid` and its fields stable until granted.

## Test plan
- Reset: `rst` high mid-burst with 2 reads in flight → no `rsp_valid` afterwards; all `ram_*` outputs are 0 and `conflict_cnt` = 0 after release.
- Write then read, with cycle-exact latency:
  - port0 writes 0xDEADBEEF to bank1 addr 0x05, next cycle reads the same location.
  - Required: read response on port0 with data 0xDEADBEEF, exactly 2 cycles after its accept.
  - Required: the write's own response carries the prior content.
- Parallel banks: port0 → bank0 and port1 → bank1 in the same cycle → both `req_ready`=1, both `ram_ena` bits set next cycle, two responses in one cycle, `conflict_cnt` unchanged.
- Round-robin: both ports continuously target bank0 for 6 cycles → grants alternate p0,p1,p0,p1,p0,p1 and `conflict_cnt` = 6.
- Saturation: force a conflict for 70000 cycles → `conflict_cnt` stops at 0xFFFF.
- Invalid bank (NUM_RAMS=3): `req_bank`=3 → `req_ready` stays 0, no `ram_ena` activity, and `conflict_cnt` increments every cycle.
